// File: rtl/rx_byte_fifo.sv
// Receive-side byte buffer for the UART receiver: acknowledges each ready byte with a
// one-cycle clear pulse, stores it in a first-word-fall-through FIFO, flags drops when full.
module rx_byte_fifo #(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk_50m,
   input  logic          rst,
   input  logic          rx_rdy,
   input  logic [7:0]    rx_data,
   output logic          rx_rdy_clr,
   output logic [7:0]    rd_data,
   output logic          rd_valid,
   input  logic          rd_ready,
   output logic [AW:0]   count,
   output logic          overflow,
   input  logic          ovf_clr
);

   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          r_rdy_clr;
   logic          r_overflow;

   logic          w_take;
   logic          w_pop;
   logic          w_push;
   logic          w_drop;

   // The receiver keeps rx_rdy high until it sees the clear, so the pending clear masks a re-take.
   assign w_take = rx_rdy & ~r_rdy_clr;
   assign w_pop  = (r_count != '0) & rd_ready;
   assign w_push = w_take & ((r_count != FULL_COUNT) | w_pop);
   assign w_drop = w_take & ~w_push;

   // NOTE: state registers use non-blocking assignments so every always_ff sees pre-edge values.
   always_ff @(posedge clk_50m) begin
      if (rst) begin
         r_rdy_clr <= 1'b0;
      end else begin
         r_rdy_clr <= w_take;
      end
   end

   always_ff @(posedge clk_50m) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // A drop in the same cycle as ovf_clr must stay visible, so the set is tested first.
   always_ff @(posedge clk_50m) begin
      if (rst) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end else if (ovf_clr) begin
         r_overflow <= 1'b0;
      end
   end

   // NOTE: storage has no reset; pointers and count alone define which entries are meaningful.
   always_ff @(posedge clk_50m) begin
      if (w_push && !rst) begin
         r_mem[r_wr_ptr] <= rx_data;
      end
   end

   assign rx_rdy_clr = r_rdy_clr;
   assign rd_data    = r_mem[r_rd_ptr];
   assign rd_valid   = (r_count != '0);
   assign count      = r_count;
   assign overflow   = r_overflow;

endmodule

// File: doc/rx_byte_fifo.md
Name: rx_byte_fifo

Overview:
- Downstream consumer of the UART receiver's byte output.
- Watches the receiver's level-type ready flag, captures each received byte, and acknowledges it with a one-cycle clear pulse.
- Buffers bytes in a first-word-fall-through FIFO with a valid/ready read port for the host logic.
- Flags, as a sticky error, any byte dropped because the FIFO was full.

Parameters:
- DEPTH, 16, number of byte entries; power of 2, at least 2.
- AW, log2(DEPTH) = 4, pointer width; count is AW+1 bits.

Ports:
- clk_50m  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- rx_rdy  input  1  receiver byte-ready level; stays high until cleared
- rx_data  input  8  receiver byte; stable while rx_rdy is high
- rx_rdy_clr  output  1  registered one-cycle acknowledge to the receiver
- rd_data  output  8  head-of-FIFO byte; valid when rd_valid is high
- rd_valid  output  1  FIFO not empty
- rd_ready  input  1  consumer accepts rd_data this cycle
- count  output  AW+1  bytes currently stored, 0..DEPTH
- overflow  output  1  sticky: a byte was dropped because the FIFO was full
- ovf_clr  input  1  clears overflow

Behaviour:
- Reset: the following are cleared on the next rising edge with rst=1:
  - write pointer, read pointer, count = 0
  - rx_rdy_clr = 0, overflow = 0, so rd_valid = 0
  - Memory contents are not reset.
  - rst has priority over every other input.
- Capture condition, take = rx_rdy & ~rx_rdy_clr:
  - The receiver drops rx_rdy one cycle after sampling the clear. The ~rx_rdy_clr term therefore blocks re-capturing the same byte during the cycle the acknowledge is high.
- On take at edge E:
  - rx_rdy_clr is 1 for exactly the cycle after E, then returns to 0.
  - The byte is pushed at E if there is room; it is dropped otherwise.
  - The receiver is always acknowledged, even when the byte is dropped, so it never stalls.
- If the receiver re-asserts rx_rdy with a new byte on the same edge it consumes the clear, the new byte is seen with rx_rdy_clr=0 in the next cycle and captured normally. No byte is lost.
- Latency: rx_rdy sampled high at edge E means rd_valid=1 and rd_data = that byte in the cycle after E, provided the FIFO was empty.
- Pop, pop = rd_valid & rd_ready:
  - The read pointer advances at the edge.
  - rd_data is combinational from memory at the read pointer (first-word fall-through).
  - rd_ready while empty has no effect.
- Room: push is accepted if count < DEPTH, or if count == DEPTH and pop occurs in the same cycle. Full plus simultaneous push and pop leaves count at DEPTH.
- Count update: count +1 on push only, -1 on pop only, unchanged on both or neither.
- Pointers are AW bits and wrap from DEPTH-1 to 0 naturally.
- Overflow:
  - Set on take when the byte is not accepted.
  - Cleared by ovf_clr.
  - If a set event and ovf_clr occur in the same cycle, set wins.
- Empty and simultaneous push: no bypass. The byte appears in the following cycle and count goes 0 to 1.
- Data ordering is strict FIFO; bytes are never reordered or duplicated.
- Implementation must be no-latch, single always block per register group; memory is inferred as a register array.

Test Plan:
- Single byte: reset, then rx_rdy=1 with rx_data=0xA5 held until rx_rdy_clr. Required:
  - rx_rdy_clr high exactly 1 cycle.
  - rd_valid=1 and rd_data=0xA5 the cycle after rx_rdy is first sampled; count=1.
  - rd_ready pulse gives count=0 and rd_valid=0.
- Fill and overflow: push 0x00..0x0F (16 bytes) with rd_ready=0, giving count=16. Then push a 17th byte 0x55. Required:
  - 0x55 is acknowledged with rx_rdy_clr.
  - overflow=1, count stays 16.
  - Draining yields 0x00..0x0F in order, never 0x55.
- Full with simultaneous push and pop: at count=16, push 0x77 while rd_ready=1. Required:
  - Pop returns 0x00, count stays 16, overflow stays 0.
  - 0x77 comes out last after 15 further pops.
- Back-to-back receiver: the receiver model re-sets rx_rdy on the same edge it sees rx_rdy_clr, giving bytes 0x11 then 0x22. Required: both are stored in order, count=2, no duplicate.
- Pointer wrap: 40 bytes streamed with rd_ready=1 continuously. Required: the output sequence equals the input sequence, count never exceeds 1, overflow=0.
- Overflow clear and reset mid-operation:
  - ovf_clr together with a new drop event: overflow stays 1. ovf_clr alone clears it to 0.
  - rst asserted with count=5: next cycle count=0, rd_valid=0, rx_rdy_clr=0, overflow=0.
  - A still-high rx_rdy is captured after rst deasserts.
